// File: rtl/friscv_cache_rd_arbiter_pkg.sv
// Shared types and helpers for the cache read-address arbiter.
package friscv_cache_rd_arbiter_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_ISSUE} arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/friscv_cache_rd_arbiter_rr.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping.
module friscv_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    logic [IDX_W-1:0] slot;

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        slot  = '0;
        for (int k = 0; k < N; k++) begin
            slot = IDX_W'((int'(rr_ptr) + k) % N);
            if (en && !valid && req[slot]) begin
                valid       = 1'b1;
                grant[slot] = 1'b1;
                index       = slot;
            end
        end
    end

endmodule

// File: rtl/friscv_cache_rd_arbiter.sv
// Shares one AXI read-address channel between NREQ cache prefetchers
// and routes completion strobes back by the low RID bits.
module friscv_cache_rd_arbiter
    import friscv_cache_rd_arbiter_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 8
) (
    input  logic                       aclk,
    input  logic                       arst,
    input  logic                       srst,
    input  logic [NREQ-1:0]            req_arvalid,
    output logic [NREQ-1:0]            req_arready,
    input  logic [NREQ*AXI_ADDR_W-1:0] req_araddr,
    input  logic [NREQ*3-1:0]          req_arprot,
    input  logic [NREQ*AXI_ID_W-1:0]   req_arid,
    output logic                       memctrl_arvalid,
    input  logic                       memctrl_arready,
    output logic [AXI_ADDR_W-1:0]      memctrl_araddr,
    output logic [2:0]                 memctrl_arprot,
    output logic [AXI_ID_W-1:0]        memctrl_arid,
    input  logic                       mem_cpl_wr,
    input  logic [AXI_ID_W-1:0]        mem_cpl_rid,
    output logic [NREQ-1:0]            req_cpl_wr,
    output logic [NREQ-1:0]            pending,
    output logic                       cpl_err
);

    localparam int IDX_W = idx_width(NREQ);
    localparam logic [AXI_ID_W-1:0] IDX_MASK = AXI_ID_W'((1 << IDX_W) - 1);

    arb_state_t state, state_nxt;

    logic [NREQ-1:0]       eligible, grant, clr_mask;
    logic [IDX_W-1:0]      rr_ptr, gidx, rid_idx, cpl_idx;
    logic                  gvalid, arb_en, cpl_act, cpl_rise, cpl_fall;
    logic [AXI_ADDR_W-1:0] sel_addr;
    logic [2:0]            sel_prot;
    logic [AXI_ID_W-1:0]   sel_id;
    logic                  rid_hi_unused;

    assign eligible      = req_arvalid & ~pending;
    assign rid_idx       = mem_cpl_rid[IDX_W-1:0];
    assign rid_hi_unused = ^mem_cpl_rid;
    assign cpl_rise      = mem_cpl_wr & ~cpl_act;
    assign cpl_fall      = ~mem_cpl_wr & cpl_act;
    assign req_arready   = grant;

    friscv_rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req    (eligible),
        .en     (arb_en),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .index  (gidx),
        .valid  (gvalid)
    );

    // No grant may be offered while either reset is held.
    always_comb begin
        state_nxt = state;
        arb_en    = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                arb_en = ~arst & ~srst;
                if (gvalid) state_nxt = ARB_ISSUE;
            end
            ARB_ISSUE: if (memctrl_arready) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        sel_addr   = '0;
        sel_prot   = '0;
        sel_id     = '0;
        req_cpl_wr = '0;
        clr_mask   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr |= req_araddr[i*AXI_ADDR_W +: AXI_ADDR_W];
                sel_prot |= req_arprot[i*3 +: 3];
                sel_id   |= req_arid[i*AXI_ID_W +: AXI_ID_W];
            end
            req_cpl_wr[i] = mem_cpl_wr & (rid_idx == IDX_W'(i));
            clr_mask[i]   = cpl_fall & (cpl_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst)      state <= ARB_IDLE;
        else if (srst) state <= ARB_IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            memctrl_arvalid <= 1'b0;
            memctrl_araddr  <= '0;
            memctrl_arprot  <= '0;
            memctrl_arid    <= '0;
            rr_ptr          <= '0;
            pending         <= '0;
            cpl_act         <= 1'b0;
            cpl_idx         <= '0;
            cpl_err         <= 1'b0;
        end else if (srst) begin
            memctrl_arvalid <= 1'b0;
            memctrl_araddr  <= '0;
            memctrl_arprot  <= '0;
            memctrl_arid    <= '0;
            rr_ptr          <= '0;
            pending         <= '0;
            cpl_act         <= 1'b0;
            cpl_idx         <= '0;
            cpl_err         <= 1'b0;
        end else begin
            if (gvalid) begin
                memctrl_arvalid <= 1'b1;
                memctrl_araddr  <= sel_addr;
                memctrl_arprot  <= sel_prot;
                memctrl_arid    <= (sel_id & ~IDX_MASK) | AXI_ID_W'(gidx);
                rr_ptr          <= IDX_W'((int'(gidx) + 1) % NREQ);
            end else if (memctrl_arvalid && memctrl_arready) begin
                memctrl_arvalid <= 1'b0;
            end
            pending <= (pending | grant) & ~clr_mask;
            // Out-of-range or non-pending owner matches no pending bit.
            if (cpl_rise) begin
                cpl_act <= 1'b1;
                cpl_idx <= rid_idx;
                if (~|(req_cpl_wr & pending)) cpl_err <= 1'b1;
            end else if (cpl_fall) begin
                cpl_act <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_friscv_cache_rd_arbiter.sv
// Bench for friscv_cache_rd_arbiter: routing table, directed corners,
// and randomized traffic against a transaction-level model.
module tb_friscv_cache_rd_arbiter;

    logic        clk;
    logic        arst, srst;
    logic [1:0]  rv, rdy;
    logic [63:0] raddr;
    logic [5:0]  rprot;
    logic [15:0] rid_in;
    logic        mvalid, mready;
    logic [31:0] maddr;
    logic [2:0]  mprot;
    logic [7:0]  mid;
    logic        cwr;
    logic [7:0]  crid;
    logic [1:0]  rcw, pend;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       wr;
        logic [7:0] rid;
        logic [1:0] exp;
    } vec_t;

    friscv_cache_rd_arbiter #(
        .NREQ(2), .AXI_ADDR_W(32), .AXI_ID_W(8)
    ) dut (
        .aclk            (clk),
        .arst            (arst),
        .srst            (srst),
        .req_arvalid     (rv),
        .req_arready     (rdy),
        .req_araddr      (raddr),
        .req_arprot      (rprot),
        .req_arid        (rid_in),
        .memctrl_arvalid (mvalid),
        .memctrl_arready (mready),
        .memctrl_araddr  (maddr),
        .memctrl_arprot  (mprot),
        .memctrl_arid    (mid),
        .mem_cpl_wr      (cwr),
        .mem_cpl_rid     (crid),
        .req_cpl_wr      (rcw),
        .pending         (pend),
        .cpl_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [7:0] id, input logic [2:0] p);
        rv[i]             = 1'b1;
        raddr[i*32 +: 32] = a;
        rid_in[i*8 +: 8]  = id;
        rprot[i*3 +: 3]   = p;
    endtask

    task automatic do_reset;
        arst   = 1'b1;
        srst   = 1'b0;
        rv     = '0;
        mready = 1'b1;
        cwr    = 1'b0;
        crid   = '0;
        tick;
        tick;
        arst = 1'b0;
        tick;
    endtask

    task automatic complete(input logic [7:0] r, input int len);
        cwr  = 1'b1;
        crid = r;
        repeat (len) tick;
        cwr = 1'b0;
        tick;
    endtask

    initial begin
        vec_t        tbl[6];
        logic        m_busy, m_valid, m_err, m_cact;
        logic [31:0] m_addr;
        logic [2:0]  m_prot;
        logic [7:0]  m_id;
        logic [1:0]  m_pend, np, exp_rdy, exp_rcw;
        int          m_ptr, m_cown, g, granted, ccnt;
        int          cq[$];

        tbl[0] = '{1'b0, 8'h04, 2'b00};
        tbl[1] = '{1'b1, 8'h04, 2'b01};
        tbl[2] = '{1'b1, 8'h05, 2'b10};
        tbl[3] = '{1'b1, 8'hFF, 2'b10};
        tbl[4] = '{1'b1, 8'hFE, 2'b01};
        tbl[5] = '{1'b0, 8'hFF, 2'b00};

        arst = 1'b1; srst = 1'b0; rv = '0; raddr = '0;
        rprot = '0; rid_in = '0; mready = 1'b1; cwr = 1'b0; crid = '0;
        tick;
        tick;
        rv = 2'b11;
        #1;
        chk("rst_arvalid", mvalid, 0);
        chk("rst_addr", maddr, 0);
        chk("rst_id", mid, 0);
        chk("rst_prot", mprot, 0);
        chk("rst_pending", pend, 0);
        chk("rst_err", err, 0);
        chk("rst_arready", rdy, 0);
        rv = '0;
        for (int i = 0; i < 6; i++) begin
            cwr  = tbl[i].wr;
            crid = tbl[i].rid;
            #2;
            chk($sformatf("route%0d", i), rcw, tbl[i].exp);
        end
        do_reset;

        // contention, pointer starts at 0
        set_req(0, 32'h100, 8'h05, 3'b010);
        set_req(1, 32'h2000, 8'hA6, 3'b001);
        #1 chk("t2_rdy_first", rdy, 2'b01);
        tick;
        rv[0] = 1'b0;
        chk("t2_addr0", maddr, 32'h100);
        chk("t2_id0", mid, 8'h04);
        chk("t2_pend0", pend, 2'b01);
        #1 chk("t2_rdy_issue", rdy, 2'b00);
        tick;
        chk("t2_hs", mvalid, 0);
        #1 chk("t2_rdy_second", rdy, 2'b10);
        tick;
        rv[1] = 1'b0;
        chk("t2_addr1", maddr, 32'h2000);
        chk("t2_id1", mid, 8'hA7);
        chk("t2_prot1", mprot, 3'b001);
        chk("t2_pend1", pend, 2'b11);
        tick;
        complete(8'h00, 1);
        complete(8'h01, 2);
        chk("t2_pend_clear", pend, 2'b00);
        rv = 2'b11;
        #1 chk("t2_rdy_again", rdy, 2'b01);
        do_reset;

        // single request and completion
        set_req(0, 32'h100, 8'h05, 3'b010);
        #1 chk("t1_rdy", rdy, 2'b01);
        tick;
        rv[0] = 1'b0;
        chk("t1_arvalid", mvalid, 1);
        chk("t1_addr", maddr, 32'h100);
        chk("t1_arid", mid, 8'h04);
        chk("t1_pend", pend, 2'b01);
        tick;
        chk("t1_hs", mvalid, 0);
        cwr  = 1'b1;
        crid = 8'h04;
        #1 chk("t1_route", rcw, 2'b01);
        tick;
        tick;
        cwr = 1'b0;
        #1 chk("t1_route_off", rcw, 2'b00);
        chk("t1_pend_hold", pend, 2'b01);
        tick;
        chk("t1_pend_clr", pend, 2'b00);
        chk("t1_err", err, 0);
        do_reset;

        // backpressure
        mready = 1'b0;
        set_req(1, 32'h3000, 8'h10, 3'b100);
        #1 chk("t3_rdy", rdy, 2'b10);
        tick;
        rv[1] = 1'b0;
        set_req(0, 32'h4000, 8'h22, 3'b000);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_rdy_held", rdy, 2'b00);
            chk("t3_valid", mvalid, 1);
            chk("t3_addr", maddr, 32'h3000);
            chk("t3_id", mid, 8'h11);
            tick;
        end
        mready = 1'b1;
        tick;
        chk("t3_hs", mvalid, 0);
        #1 chk("t3_next_grant", rdy, 2'b01);
        tick;
        rv[0] = 1'b0;
        chk("t3_addr_next", maddr, 32'h4000);
        chk("t3_id_next", mid, 8'h22);
        do_reset;

        // single outstanding per requester
        set_req(0, 32'h500, 8'h30, 3'b000);
        #1 chk("t4_rdy", rdy, 2'b01);
        tick;
        rv[0] = 1'b0;
        tick;
        set_req(0, 32'h600, 8'h30, 3'b000);
        for (int c = 0; c < 3; c++) begin
            #1 chk("t4_blocked", rdy, 2'b00);
            tick;
        end
        cwr  = 1'b1;
        crid = 8'h00;
        #1 chk("t4_blocked_cpl", rdy, 2'b00);
        tick;
        cwr = 1'b0;
        #1 chk("t4_fall_blocked", rdy, 2'b00);
        tick;
        #1 chk("t4_regrant", rdy, 2'b01);
        tick;
        rv[0] = 1'b0;
        chk("t4_addr", maddr, 32'h600);
        do_reset;

        // completion to a non-pending requester
        cwr  = 1'b1;
        crid = 8'h03;
        #1 chk("t5_route", rcw, 2'b10);
        chk("t5_err_before", err, 0);
        tick;
        chk("t5_err", err, 1);
        cwr = 1'b0;
        tick;
        tick;
        chk("t5_sticky", err, 1);
        chk("t5_pend", pend, 2'b00);
        do_reset;
        chk("t5_err_rst", err, 0);

        // async reset mid-backpressure
        mready = 1'b0;
        set_req(0, 32'h700, 8'h41, 3'b001);
        tick;
        rv[0] = 1'b0;
        set_req(1, 32'h800, 8'h52, 3'b010);
        tick;
        chk("t6_issue", mvalid, 1);
        #2 arst = 1'b1;
        #1;
        chk("t6_arst_valid", mvalid, 0);
        chk("t6_arst_addr", maddr, 0);
        chk("t6_arst_id", mid, 0);
        chk("t6_arst_prot", mprot, 0);
        chk("t6_arst_pend", pend, 0);
        chk("t6_arst_rdy", rdy, 0);
        tick;
        rv = '0;
        arst = 1'b0;
        tick;
        // same scenario through the synchronous reset
        set_req(0, 32'h700, 8'h41, 3'b001);
        tick;
        rv[0] = 1'b0;
        tick;
        chk("t6s_issue", mvalid, 1);
        srst  = 1'b1;
        rv[1] = 1'b1;
        #1 chk("t6s_before_edge", mvalid, 1);
        tick;
        chk("t6s_valid", mvalid, 0);
        chk("t6s_addr", maddr, 0);
        chk("t6s_id", mid, 0);
        chk("t6s_pend", pend, 0);
        chk("t6s_rdy", rdy, 0);
        srst = 1'b0;
        do_reset;

        // randomized traffic
        m_busy = 0; m_valid = 0; m_err = 0; m_cact = 0;
        m_addr = '0; m_prot = '0; m_id = '0; m_pend = '0;
        m_ptr = 0; m_cown = 0; granted = -1; ccnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            chk("rnd_arvalid", mvalid, m_valid);
            chk("rnd_addr", maddr, m_addr);
            chk("rnd_id", mid, m_id);
            chk("rnd_prot", mprot, m_prot);
            chk("rnd_pending", pend, m_pend);
            chk("rnd_err", err, m_err);
            if (granted >= 0) rv[granted] = 1'b0;
            for (int i = 0; i < 2; i++)
                if (!rv[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom & 32'hFFFF_FFFC, 8'($urandom),
                            3'($urandom));
            mready = 1'($urandom_range(0, 1));
            if (ccnt > 0) begin
                ccnt--;
            end else if (cwr) begin
                cwr = 1'b0;
            end else if (cq.size() > 0 && $urandom_range(0, 1) == 1) begin
                m_cown = cq.pop_front();
                crid   = 8'(($urandom & 32'hFE) | m_cown);
                cwr    = 1'b1;
                ccnt   = $urandom_range(0, 2);
            end
            #1;
            g = -1;
            if (!m_busy)
                for (int k = 0; k < 2; k++)
                    if (g < 0 && rv[(m_ptr + k) % 2] &&
                        !m_pend[(m_ptr + k) % 2])
                        g = (m_ptr + k) % 2;
            exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            exp_rcw = cwr ? 2'(1 << crid[0]) : 2'b00;
            chk("rnd_arready", rdy, exp_rdy);
            chk("rnd_cpl_route", rcw, exp_rcw);
            np = m_pend;
            if (cwr && !m_cact) begin
                m_cact = 1;
                m_cown = int'(crid[0]);
                if (!m_pend[m_cown]) m_err = 1;
            end else if (!cwr && m_cact) begin
                m_cact       = 0;
                np[m_cown]   = 1'b0;
            end
            if (g >= 0) begin
                np[g]   = 1'b1;
                m_valid = 1;
                m_busy  = 1;
                m_addr  = raddr[g*32 +: 32];
                m_prot  = rprot[g*3 +: 3];
                m_id    = {rid_in[g*8+1 +: 7], g[0]};
                m_ptr   = (g + 1) % 2;
            end else if (m_busy && mready) begin
                m_busy  = 0;
                m_valid = 0;
                cq.push_back(int'(m_id[0]));
            end
            m_pend  = np;
            granted = g;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
